// File: rtl/seq_alu.sv
// seq_alu: handshaked W-bit accumulating ALU with
// iterative shift-add multiply and restoring divide.
module seq_alu #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic         acc_sel,
  input  logic [W-1:0] input1,
  input  logic [W-1:0] input2,
  output logic [W-1:0] out,
  output logic [W-1:0] out_hi,
  output logic         out_valid,
  output logic         zero,
  output logic         carry,
  output logic         dz,
  output logic         err
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_RST  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  wh_q, wh_d;
  logic [W-1:0]  wl_q, wl_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  hi_q, hi_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          dz_q, dz_d;
  logic          err_q, err_d;
  logic          ov_q, ov_d;

  logic [W-1:0]  opa, opb;
  logic [W:0]    add_r, sub_r, mac, dsh, dsub;
  logic          fin, carry_c, dz_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    b_d     = b_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    fin     = 1'b0;
    carry_c = 1'b0;
    dz_c    = 1'b0;
    opa     = acc_sel ? out_q : input1;
    opb     = input2;
    add_r   = {1'b0, opa} + {1'b0, opb};
    sub_r   = {1'b0, opa} - {1'b0, opb};
    mac     = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
    dsh     = {wh_q, wl_q[W-1]};
    dsub    = dsh - {1'b0, b_q};

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (opcode)
            OP_NOOP: fin = 1'b1;
            OP_ADD: begin
              fin     = 1'b1;
              out_d   = add_r[W-1:0];
              hi_d    = '0;
              carry_c = add_r[W];
            end
            OP_SUB: begin
              fin     = 1'b1;
              out_d   = sub_r[W-1:0];
              hi_d    = '0;
              carry_c = sub_r[W];
            end
            OP_MUL: begin
              state_d = S_MUL;
              cnt_d   = CW'(W);
              wh_d    = '0;
              wl_d    = opa;
              b_d     = opb;
            end
            OP_DIV: begin
              if (opb == '0) begin
                fin   = 1'b1;
                out_d = '1;
                hi_d  = opa;
                dz_c  = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(W);
                wh_d    = '0;
                wl_d    = opa;
                b_d     = opb;
              end
            end
            OP_AND: begin
              fin   = 1'b1;
              out_d = opa & opb;
              hi_d  = '0;
            end
            OP_OR: begin
              fin   = 1'b1;
              out_d = opa | opb;
              hi_d  = '0;
            end
            OP_XOR: begin
              fin   = 1'b1;
              out_d = opa ^ opb;
              hi_d  = '0;
            end
            OP_NOT: begin
              fin   = 1'b1;
              out_d = ~opa;
              hi_d  = '0;
            end
            OP_RST: begin
              ov_d    = 1'b1;
              out_d   = '0;
              hi_d    = '0;
              zero_d  = 1'b0;
              carry_d = 1'b0;
              dz_d    = 1'b0;
              err_d   = 1'b0;
            end
            default: begin
              ov_d  = 1'b1;
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        cnt_d        = cnt_q - CW'(1);
        {wh_d, wl_d} = {mac, wl_q[W-1:1]};
      end
      S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        // restore by keeping the shifted remainder when the trial goes negative
        if (!dsub[W]) begin
          wh_d = dsub[W-1:0];
          wl_d = {wl_q[W-2:0], 1'b1};
        end else begin
          wh_d = dsh[W-1:0];
          wl_d = {wl_q[W-2:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && cnt_q == CW'(1)) begin
      state_d = S_IDLE;
      out_d   = wl_d;
      hi_d    = wh_d;
      fin     = 1'b1;
    end

    if (fin) begin
      ov_d    = 1'b1;
      zero_d  = (out_d == '0);
      carry_d = carry_c;
      dz_d    = dz_c;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      b_q     <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      b_q     <= b_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out       = out_q;
  assign out_hi    = hi_q;
  assign out_valid = ov_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dz        = dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu (W=16).
// obs packs {in_ready,out_valid,zero,carry,dz,err,out,out_hi}.
module tb_seq_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic         acc_sel;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         out_valid;
  logic         zero;
  logic         carry;
  logic         dz;
  logic         err;

  logic [2*W+5:0] obs;
  logic [2*W+5:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign obs = {in_ready, out_valid, zero, carry, dz, err, out, out_hi};

  seq_alu #(.W(W)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .input1    (input1),
    .input2    (input2),
    .out       (out),
    .out_hi    (out_hi),
    .out_valid (out_valid),
    .zero      (zero),
    .carry     (carry),
    .dz        (dz),
    .err       (err)
  );

  task automatic go(input logic [3:0] op, input logic sel,
                    input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    acc_sel  = sel;
    input1   = a;
    input2   = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    opcode   = 4'h0;
    acc_sel  = 1'b0;
    input1   = '0;
    input2   = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    clear = 1'b1;
    tick();
    tick();
    go(4'h1, 1'b0, 16'd5, 16'd5);
    tick();
    clear = 1'b0;
    idle();
    exp_v = {6'b100000, 16'h0000, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    tick();
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL req_during_clear: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_add();
    go(4'h1, 1'b0, 16'd1, 16'd1);
    tick();
    idle();
    exp_v = {6'b110000, 16'd2, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL add_1_1: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = {6'b100000, 16'd2, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL add_pulse_end: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_add_sub();
    go(4'h1, 1'b0, 16'hFFFF, 16'h0001);
    tick();
    go(4'h2, 1'b0, 16'h0001, 16'h0002);
    exp_v = {6'b111100, 16'h0000, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL add_wrap: got %h want %h", obs, exp_v);
    end
    tick();
    idle();
    exp_v = {6'b110100, 16'hFFFF, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL sub_borrow: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = {6'b100100, 16'hFFFF, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL sub_hold: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_mult();
    int lows;
    int pulses;
    lows = 0;
    pulses = 0;
    go(4'h3, 1'b0, 16'h0100, 16'h0100);
    tick();
    idle();
    for (int i = 1; i <= W; i++) begin
      if (!in_ready) lows++;
      if (out_valid) pulses++;
      tick();
    end
    n_cmp++;
    if (lows !== W || pulses !== 0) begin
      n_bad++;
      $display("FAIL mult_busy: got lows=%0d pulses=%0d want %0d/0",
               lows, pulses, W);
    end
    exp_v = {6'b111000, 16'h0000, 16'h0001};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL mult_result: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = {6'b101000, 16'h0000, 16'h0001};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL mult_single_pulse: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_div();
    int lows;
    int pulses;
    lows = 0;
    pulses = 0;
    go(4'h4, 1'b0, 16'd100, 16'd7);
    tick();
    idle();
    for (int i = 1; i <= W; i++) begin
      if (!in_ready) lows++;
      if (out_valid) pulses++;
      tick();
    end
    n_cmp++;
    if (lows !== W || pulses !== 0) begin
      n_bad++;
      $display("FAIL div_busy: got lows=%0d pulses=%0d want %0d/0",
               lows, pulses, W);
    end
    exp_v = {6'b110000, 16'd14, 16'd2};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL div_100_7: got %h want %h", obs, exp_v);
    end
    go(4'h4, 1'b0, 16'd5, 16'd0);
    tick();
    idle();
    exp_v = {6'b110010, 16'hFFFF, 16'd5};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL div_by_zero: got %h want %h", obs, exp_v);
    end
    tick();
    exp_v = {6'b100010, 16'hFFFF, 16'd5};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL div_zero_hold: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    go(4'h1, 1'b0, 16'd5, 16'd3);
    tick();
    go(4'h1, 1'b1, 16'h1234, 16'd2);
    exp_v = {6'b110000, 16'd8, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL chain_add: got %h want %h", obs, exp_v);
    end
    tick();
    go(4'h2, 1'b1, 16'h4321, 16'd10);
    exp_v = {6'b110000, 16'd10, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL chain_acc_add: got %h want %h", obs, exp_v);
    end
    tick();
    go(4'hA, 1'b0, 16'd7, 16'd7);
    exp_v = {6'b111000, 16'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL chain_acc_sub: got %h want %h", obs, exp_v);
    end
    tick();
    idle();
    exp_v = {6'b111001, 16'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL illegal_op: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_noop_reset();
    go(4'h0, 1'b0, 16'd3, 16'd3);
    tick();
    go(4'h4, 1'b0, 16'd9, 16'd0);
    exp_v = {6'b111000, 16'd0, 16'h0000};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL noop: got %h want %h", obs, exp_v);
    end
    tick();
    go(4'hF, 1'b0, 16'd0, 16'd0);
    exp_v = {6'b110010, 16'hFFFF, 16'd9};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL div_9_0: got %h want %h", obs, exp_v);
    end
    tick();
    idle();
    exp_v = {6'b110000, 16'd0, 16'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_op: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_clear_abort();
    int pulses;
    pulses = 0;
    go(4'h1, 1'b0, 16'd9, 16'd0);
    tick();
    go(4'h3, 1'b0, 16'd3, 16'd3);
    exp_v = {6'b110000, 16'd9, 16'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL pre_abort_add: got %h want %h", obs, exp_v);
    end
    tick();
    idle();
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_v = {6'b100000, 16'd0, 16'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL abort_state: got %h want %h", obs, exp_v);
    end
    for (int c = 6; c <= 20; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses);
    end
    go(4'h1, 1'b0, 16'd2, 16'd2);
    tick();
    idle();
    exp_v = {6'b110000, 16'd4, 16'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL post_abort_add: got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    clear = 1'b1;
    idle();
    test_reset();
    test_add();
    test_add_sub();
    test_mult();
    test_div();
    test_back_to_back();
    test_noop_reset();
    test_clear_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
